// File: rtl/onchip_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// Grants are registered, one access at a time, with read data routed back to the winner.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5120
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                m0_valid,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_ack,
  output logic                m0_readdatavalid,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_err,

  input  logic                m1_valid,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_ack,
  output logic                m1_readdatavalid,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_err,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  output logic                mem_reset_req,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t              state;
  logic                last_grant;
  logic                owner;
  logic                req_write;
  logic                req_oor;
  logic [ADDR_W-1:0]   req_address;
  logic [BE_W-1:0]     req_byteenable;
  logic [DATA_W-1:0]   req_writedata;

  logic                pick_m1;
  logic                pick_write;
  logic                pick_oor;
  logic [ADDR_W-1:0]   pick_address;
  logic [BE_W-1:0]     pick_byteenable;
  logic [DATA_W-1:0]   pick_writedata;

  // m1 wins when alone, or when both ask and m0 was the previous winner
  assign pick_m1         = m1_valid && (!m0_valid || !last_grant);
  assign pick_write      = pick_m1 ? m1_write      : m0_write;
  assign pick_address    = pick_m1 ? m1_address    : m0_address;
  assign pick_byteenable = pick_m1 ? m1_byteenable : m0_byteenable;
  assign pick_writedata  = pick_m1 ? m1_writedata  : m0_writedata;
  assign pick_oor        = {1'b0, pick_address} >= LIMIT;

  assign mem_address    = req_address;
  assign mem_byteenable = req_byteenable;
  assign mem_writedata  = req_writedata;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      owner            <= 1'b0;
      req_write        <= 1'b0;
      req_oor          <= 1'b0;
      req_address      <= '0;
      req_byteenable   <= '0;
      req_writedata    <= '0;
      mem_chipselect   <= 1'b0;
      mem_write        <= 1'b0;
      m0_ack           <= 1'b0;
      m1_ack           <= 1'b0;
      m0_err           <= 1'b0;
      m1_err           <= 1'b0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
    end else begin
      mem_chipselect   <= 1'b0;
      mem_write        <= 1'b0;
      m0_ack           <= 1'b0;
      m1_ack           <= 1'b0;
      m0_err           <= 1'b0;
      m1_err           <= 1'b0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            owner          <= pick_m1;
            req_write      <= pick_write;
            req_oor        <= pick_oor;
            req_address    <= pick_address;
            req_byteenable <= pick_byteenable;
            req_writedata  <= pick_writedata;
            // Out-of-range requests are acknowledged but never reach the RAM
            mem_chipselect <= !pick_oor;
            mem_write      <= pick_write && !pick_oor;
            m0_ack         <= !pick_m1;
            m1_ack         <= pick_m1;
            m0_err         <= !pick_m1 && pick_oor;
            m1_err         <= pick_m1 && pick_oor;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          last_grant <= owner;
          state      <= req_write ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (owner) begin
            m1_readdata      <= req_oor ? '0 : mem_readdata;
            m1_readdatavalid <= 1'b1;
          end else begin
            m0_readdata      <= req_oor ? '0 : mem_readdata;
            m0_readdatavalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: directed scenarios plus randomized traffic
// from both requesters, checked against a word-array memory model and arbitration rules.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 5120;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_write, m0_ack, m0_readdatavalid, m0_err;
  logic [12:0] m0_address;
  logic [3:0]  m0_byteenable;
  logic [31:0] m0_writedata, m0_readdata;
  logic        m1_valid, m1_write, m1_ack, m1_readdatavalid, m1_err;
  logic [12:0] m1_address;
  logic [3:0]  m1_byteenable;
  logic [31:0] m1_writedata, m1_readdata;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [31:0] mem_writedata, mem_readdata;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata), .m0_ack(m0_ack),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_ack(m1_ack),
    .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [12:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    int          issue_cyc;
    int          exp_lat;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          due_cyc;
  } rd_t;

  req_t        req_q0[$];
  req_t        req_q1[$];
  rd_t         rd_q0[$];
  rd_t         rd_q1[$];
  int          grant_log[$];
  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] ref_mem [int];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] preload(int a);
    return (32'(a) * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  // RAM stand-in: registered read port, data one cycle after the address edge
  initial for (int i = 0; i < DEPTH; i++) ram[i] = preload(i);

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken && int'(mem_address) < DEPTH) begin
      mem_readdata <= ram[mem_address];
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
    end
  end

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_read(int a);
    if (a >= DEPTH) return 32'h0;
    if (ref_mem.exists(a)) return ref_mem[a];
    return preload(a);
  endfunction

  function automatic void ref_write(int a, logic [3:0] be, logic [31:0] d);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Called by the monitor on an ack: checks the RAM strobes and schedules any read return
  task automatic checkAck(int m, req_t r);
    logic oor;
    rd_t  e;
    oor = int'(r.address) >= DEPTH;
    checkOutput($sformatf("m%0d_err", m), 32'(m == 1 ? m1_err : m0_err), 32'(oor));
    checkOutput($sformatf("m%0d_other_ack", m), 32'(m == 1 ? m0_ack : m1_ack), 32'd0);
    checkOutput("mem_chipselect", 32'(mem_chipselect), 32'(!oor));
    checkOutput("mem_write", 32'(mem_write), 32'(r.write && !oor));
    if (r.exp_lat != 0)
      checkOutput($sformatf("m%0d_ack_latency", m), 32'(cyc - r.issue_cyc), 32'(r.exp_lat));
    else
      checkOutput($sformatf("m%0d_ack_wait_le6", m), 32'((cyc - r.issue_cyc) <= 6), 32'd1);
    if (!oor) begin
      checkOutput("mem_address", 32'(mem_address), 32'(r.address));
      if (r.write) begin
        checkOutput("mem_writedata", mem_writedata, r.writedata);
        checkOutput("mem_byteenable", 32'(mem_byteenable), 32'(r.byteenable));
        ref_write(int'(r.address), r.byteenable, r.writedata);
      end
    end
    if (!r.write) begin
      e.data    = ref_read(int'(r.address));
      e.due_cyc = cyc + 2;
      if (m == 1) rd_q1.push_back(e); else rd_q0.push_back(e);
    end
    grant_log.push_back(m);
  endtask

  task automatic checkRead(int m, rd_t e, logic [31:0] data);
    checkOutput($sformatf("m%0d_readdata", m), data, e.data);
    checkOutput($sformatf("m%0d_rdv_cycle", m), 32'(cyc), 32'(e.due_cyc));
  endtask

  always @(negedge clk) begin
    if (m0_ack) begin
      checkOutput("m0_ack_has_request", 32'(req_q0.size() != 0), 32'd1);
      if (req_q0.size() != 0) checkAck(0, req_q0.pop_front());
    end
    if (m1_ack) begin
      checkOutput("m1_ack_has_request", 32'(req_q1.size() != 0), 32'd1);
      if (req_q1.size() != 0) checkAck(1, req_q1.pop_front());
    end
    if (m0_readdatavalid) begin
      checkOutput("m0_rdv_expected", 32'(rd_q0.size() != 0), 32'd1);
      if (rd_q0.size() != 0) checkRead(0, rd_q0.pop_front(), m0_readdata);
    end
    if (m1_readdatavalid) begin
      checkOutput("m1_rdv_expected", 32'(rd_q1.size() != 0), 32'd1);
      if (rd_q1.size() != 0) checkRead(1, rd_q1.pop_front(), m1_readdata);
    end
    if (mem_chipselect) checkOutput("cs_only_with_ack", 32'(m0_ack | m1_ack), 32'd1);
    if (m0_err) checkOutput("m0_err_with_ack", 32'(m0_ack), 32'd1);
    if (m1_err) checkOutput("m1_err_with_ack", 32'(m1_ack), 32'd1);
  end

  // Enters and leaves at negedge+1; holds valid until the ack is seen
  task automatic applyStimulus(int m, logic w, logic [12:0] a, logic [3:0] be,
                               logic [31:0] d, int lat);
    req_t r;
    int   n;
    logic acked;
    r.write = w; r.address = a; r.byteenable = be; r.writedata = d;
    r.issue_cyc = cyc; r.exp_lat = lat;
    if (m == 1) begin
      req_q1.push_back(r);
      m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d; m1_valid = 1'b1;
    end else begin
      req_q0.push_back(r);
      m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d; m0_valid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      acked = (m == 1) ? m1_ack : m0_ack;
    end while (!acked && n < 50);
    if (!acked) begin
      checks++;
      errors++;
      $display("[TB] FAIL m%0d_ack_timeout: got no ack, required ack within 50 cycles", m);
    end
    #1;
    if (m == 1) m1_valid = 1'b0; else m0_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((req_q0.size() + req_q1.size() + rd_q0.size() + rd_q1.size()) != 0 && n < 40);
    checkOutput("drain", 32'(req_q0.size() + req_q1.size() + rd_q0.size() + rd_q1.size()), 32'd0);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    req_q0.delete(); req_q1.delete(); rd_q0.delete(); rd_q1.delete();
    @(negedge clk);
    checkOutput("rst_pulses", 32'({m0_ack, m1_ack, m0_readdatavalid, m1_readdatavalid,
                                   m0_err, m1_err, mem_chipselect, mem_write}), 32'd0);
    checkOutput("rst_m0_readdata", m0_readdata, 32'd0);
    checkOutput("rst_m1_readdata", m1_readdata, 32'd0);
    checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
    checkOutput("rst_mem_writedata", mem_writedata, 32'd0);
    checkOutput("rst_mem_byteenable", 32'(mem_byteenable), 32'd0);
    checkOutput("mem_clken", 32'(mem_clken), 32'd1);
    checkOutput("mem_reset_req_high", 32'(mem_reset_req), 32'd1);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mem_reset_req_low", 32'(mem_reset_req), 32'd0);
    #1;
  endtask

  function automatic logic [12:0] randomAddress();
    case ($urandom_range(0, 5))
      0:       return 13'd5119;
      1:       return 13'd5120;
      2:       return 13'h1FFF;
      default: return 13'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    m0_valid = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_valid = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    @(negedge clk);
    #1;
    applyReset();

    applyStimulus(0, 1'b1, 13'h0010, 4'hF, 32'hCAFEBABE, 1);
    waitIdle();
    applyStimulus(0, 1'b0, 13'h0010, 4'hF, 32'h0, 1);
    waitIdle();
    checkOutput("m0_cafebabe", m0_readdata, 32'hCAFEBABE);
    checkOutput("m1_readdata_untouched", m1_readdata, 32'h0);

    applyStimulus(0, 1'b1, 13'h0100, 4'hF, 32'h11223344, 1);
    waitIdle();
    applyStimulus(0, 1'b1, 13'h0100, 4'h5, 32'hAABBCCDD, 1);
    waitIdle();
    applyStimulus(0, 1'b0, 13'h0100, 4'hF, 32'h0, 1);
    waitIdle();
    checkOutput("byteenable_merge", m0_readdata, 32'h11BB33DD);

    // Contention straight out of reset: m0 takes the first grant, then strict alternation
    applyReset();
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 13'h0001, 4'hF, 32'h0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 13'h0002, 4'hF, 32'h0, 0);
    join
    waitIdle();
    checkOutput("contention_grants", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++)
      checkOutput($sformatf("contention_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    applyStimulus(1, 1'b1, 13'd5120, 4'hF, 32'h12345678, 1);
    waitIdle();
    applyStimulus(1, 1'b0, 13'd5120, 4'hF, 32'h0, 1);
    waitIdle();
    checkOutput("m1_oor_5120_data", m1_readdata, 32'h0);
    applyStimulus(1, 1'b0, 13'h1FFF, 4'hF, 32'h0, 1);
    waitIdle();
    applyStimulus(1, 1'b1, 13'd5119, 4'hF, 32'h0BADF00D, 1);
    waitIdle();
    applyStimulus(1, 1'b0, 13'd5119, 4'hF, 32'h0, 1);
    waitIdle();
    checkOutput("m1_last_word", m1_readdata, 32'h0BADF00D);

    // m1 held the last grant, so m0's write lands before m1's read of the same word
    grant_log.delete();
    fork
      applyStimulus(0, 1'b1, 13'd7, 4'hF, 32'h5, 0);
      applyStimulus(1, 1'b0, 13'd7, 4'hF, 32'h0, 0);
    join
    waitIdle();
    checkOutput("race_first_grant", 32'(grant_log[0]), 32'd0);
    checkOutput("race_m1_data", m1_readdata, 32'h5);

    // Reset lands while the read is waiting on the RAM, so its data must never surface
    applyStimulus(0, 1'b0, 13'h0010, 4'hF, 32'h0, 1);
    @(negedge clk);
    #1;
    applyReset();
    repeat (3) begin @(negedge clk); #1; end
    grant_log.delete();
    fork
      applyStimulus(0, 1'b0, 13'h0020, 4'hF, 32'h0, 0);
      applyStimulus(1, 1'b0, 13'h0021, 4'hF, 32'h0, 0);
    join
    waitIdle();
    checkOutput("post_reset_grants", 32'(grant_log.size()), 32'd2);
    checkOutput("post_reset_first", 32'(grant_log[0]), 32'd0);

    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
        applyStimulus(0, 1'($urandom_range(0, 1)), randomAddress(),
                      4'($urandom_range(0, 15)), $urandom, 0);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
        applyStimulus(1, 1'($urandom_range(0, 1)), randomAddress(),
                      4'($urandom_range(0, 15)), $urandom, 0);
      end
    join
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port 5120x32 on-chip RAM (13-bit word address, 4 byte enables, read data valid one cycle after the address edge).
- Serialises requests from two masters (CPU data side m0, DMA/accelerator m1) onto the one RAM port.
- Registers the grant, drives the RAM strobes, returns read data with a valid pulse to the winning requester.
- Range-checks addresses against the RAM depth.

Parameters:
- ADDR_W, 13, word-address width of the RAM and of each requester.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- DEPTH, 5120, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_valid  in  1  requester 0 has a request; held with its fields until m0_ack.
- m0_write  in  1  1=write, 0=read.
- m0_address  in  ADDR_W  word address.
- m0_byteenable  in  DATA_W/8  byte lanes for writes.
- m0_writedata  in  DATA_W  write data.
- m0_ack  out  1  one-cycle pulse: request accepted, requester may drop or change fields next cycle.
- m0_readdatavalid  out  1  one-cycle pulse with m0_readdata.
- m0_readdata  out  DATA_W  read data.
- m0_err  out  1  one-cycle pulse, coincident with m0_ack, on an out-of-range address.
- m1_*: identical set for requester 1.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  DATA_W/8  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken; constant 1.
- mem_reset_req  out  1  to RAM reset_req; equals reset.
- mem_readdata  in  DATA_W  from RAM readdata.

Behaviour:
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If any valid is high, pick a winner, register its fields and the winner id, go to ACCESS.
  - Round-robin: if both valid, winner is the requester not granted last. last_grant resets to 1, so m0 wins the first contention.
  - A single valid always wins.
- ACCESS (one cycle):
  - Drive mem_* from the registered fields; mem_chipselect=1, mem_write=registered write.
  - Pulse the winner's ack; update last_grant.
  - Write goes to IDLE; read goes to RDWAIT.
- RDWAIT (one cycle):
  - Capture mem_readdata into the winner's readdata register and go to IDLE.
  - The winner's readdatavalid pulses in the following cycle, which is IDLE or the next ACCESS.
- Latency, request valid first seen in cycle N:
  - Ack in N+1.
  - Write committed at the end of N+1.
  - Readdatavalid in N+3.
  - Back-to-back: a write costs 2 cycles per access, a read 3.
- Fairness: continuous valid on both sides alternates grants m0, m1, m0, …; neither waits more than one foreign access.
- Out-of-range (address >= DEPTH):
  - Accepted normally: ack and err pulse in ACCESS.
  - mem_chipselect and mem_write forced 0, so the RAM is not touched.
  - Read still passes through RDWAIT and returns readdata=0 with readdatavalid.
- Outside ACCESS: mem_chipselect=0 and mem_write=0. mem_address and mem_writedata hold their last registered values.
- Requester dropping valid before ack is a protocol violation; no defined behaviour is required.
- A requester's valid remaining high after its ack is treated as a new request.
- Reset (synchronous, any state):
  - State goes to IDLE, last_grant to 1.
  - All ack, readdatavalid, err and mem_chipselect/mem_write drop to 0 the cycle after reset is sampled high.
  - readdata registers clear to 0.
  - An in-flight read is discarded: no readdatavalid.
  - mem_reset_req follows reset combinationally.
- Reset values: all outputs 0 except mem_clken=1 (and mem_reset_req=reset).

Test Plan:
- Single write then read, m0: write 0xCAFEBABE to addr 0x0010 with be=0xF, then read 0x0010 → ack at N+1, readdatavalid at N+3 with 0xCAFEBABE; m1 outputs stay 0.
- Byte enables: write 0x11223344 with be=0xF, then 0xAABBCCDD with be=0x5 to addr 0x0100 → readback 0x11BB33DD.
- Contention: both valid from reset, continuous reads to 0x0001 (m0) and 0x0002 (m1) → grants m0, m1, m0, m1; each readdatavalid goes only to its owner, with correct data.
- Out of range: m1 writes 0x12345678 to 5120, then reads 5120 and 0x1FFF → err pulses with each ack, mem_chipselect never 1, reads return 0. Address 5119 works normally.
- Reset mid-read: m0 read acked, reset asserted in RDWAIT → no readdatavalid. After reset, simultaneous requests grant m0 first.
- Write-then-read race: m0 writes 0x5 to addr 7 while m1 reads addr 7, m0 granted first → m1 readdata=0x5.
